// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM sequence controller: default word formats,
// FSM state encoding and the Q8.8 data word type.
package lstm_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRACT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef logic signed [DATA_WIDTH_DEF-1:0] q8_8_t;

endpackage

// File: rtl/lstm_seq_ctrl.sv
// Step sequencer for an external LSTM cell: accepts one sample, waits CELL_LAT
// cycles for the cell, holds the result until consumed, carries c/h between steps.
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRACT_WIDTH = FRACT_WIDTH_DEF,
    parameter int STEP_W      = 8,
    parameter int CELL_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] cell_x,
    output logic [DATA_WIDTH-1:0] cell_c_in,
    output logic [DATA_WIDTH-1:0] cell_h_in,
    input  logic [DATA_WIDTH-1:0] cell_c_out,
    input  logic [DATA_WIDTH-1:0] cell_h_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_h,
    output logic [DATA_WIDTH-1:0] out_c,
    output logic                  out_last,
    output logic [STEP_W-1:0]     out_step,
    output logic                  step_ovf
);

    localparam int              WAIT_W   = 4;
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    // FRACT_WIDTH only describes the format; reject nonsensical parameter sets.
    if (CELL_LAT < 1 || CELL_LAT > 15 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_param
        $error("lstm_seq_ctrl: illegal CELL_LAT or FRACT_WIDTH");
    end

    state_e                state_q,    state_d;
    logic [DATA_WIDTH-1:0] x_q,        x_d;
    logic                  last_q,     last_d;
    logic [DATA_WIDTH-1:0] c_q,        c_d;
    logic [DATA_WIDTH-1:0] h_q,        h_d;
    logic [WAIT_W-1:0]     wait_q,     wait_d;
    logic [DATA_WIDTH-1:0] out_c_q,    out_c_d;
    logic [DATA_WIDTH-1:0] out_h_q,    out_h_d;
    logic                  out_last_q, out_last_d;
    logic [STEP_W-1:0]     step_q,     step_d;
    logic                  ovf_q,      ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            last_q     <= 1'b0;
            c_q        <= '0;
            h_q        <= '0;
            wait_q     <= '0;
            out_c_q    <= '0;
            out_h_q    <= '0;
            out_last_q <= 1'b0;
            step_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            last_q     <= last_d;
            c_q        <= c_d;
            h_q        <= h_d;
            wait_q     <= wait_d;
            out_c_q    <= out_c_d;
            out_h_q    <= out_h_d;
            out_last_q <= out_last_d;
            step_q     <= step_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        last_d     = last_q;
        c_d        = c_q;
        h_d        = h_q;
        wait_d     = wait_q;
        out_c_d    = out_c_q;
        out_h_d    = out_h_q;
        out_last_d = out_last_q;
        step_d     = step_q;
        ovf_d      = ovf_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = !clr;
                if (clr) begin
                    c_d    = '0;
                    h_d    = '0;
                    step_d = '0;
                    ovf_d  = 1'b0;
                end else if (in_valid) begin
                    x_d     = in_x;
                    last_d  = in_last;
                    wait_d  = WAIT_W'(CELL_LAT - 1);
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (wait_q == '0) begin
                    out_c_d    = cell_c_out;
                    c_d        = cell_c_out;
                    out_h_d    = cell_h_out;
                    h_d        = cell_h_out;
                    out_last_d = last_q;
                    state_d    = ST_HOLD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                    // Final step of a sequence starts the next one from a clean state.
                    if (out_last_q) begin
                        c_d    = '0;
                        h_d    = '0;
                        step_d = '0;
                    end else if (step_q == STEP_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cell_x    = x_q;
    assign cell_c_in = c_q;
    assign cell_h_in = h_q;
    assign out_c     = out_c_q;
    assign out_h     = out_h_q;
    assign out_last  = out_last_q;
    assign out_step  = step_q;
    assign step_ovf  = ovf_q;

endmodule
